// File: rtl/uart_bus_pkg.sv
// Shared bus definitions for the UART bus initiator and the peripheral's
// addressable logic.
package uart_bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_WAIT,
    WR_STROBE,
    RD_STROBE,
    RD_WAIT,
    RD_HOLD,
    DONE
  } bus_state_t;

  typedef enum logic {
    READ,
    WRITE
  } bus_dir_t;

endpackage

// File: rtl/latency_counter.sv
// Down-counter that marks the cycle on which read data is valid after a
// read strobe. expired is high when the count has reached zero.
module latency_counter #(
  parameter int latency = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic tick,
  output logic expired
);

  localparam int CW = (latency > 1) ? $clog2(latency) : 1;

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= CW'(latency - 1);
    end else if (tick && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/uart_bus_initiator.sv
// Turns write/read burst commands into single-cycle strobes on a simple
// peripheral bus, with stream handshakes for the data words.
//
//   state     | meaning
//   IDLE      | cmd_ready high, waiting for a command
//   WR_WAIT   | wr_ready high, waiting for the next write word
//   WR_STROBE | write_enable pulse with the captured word
//   RD_STROBE | read_enable pulse
//   RD_WAIT   | waiting read_latency cycles for data_out
//   RD_HOLD   | rd_valid held until rd_ready
//   DONE      | one-cycle done pulse
module uart_bus_initiator
  import uart_bus_pkg::*;
#(
  parameter int                     width         = 8,
  parameter int                     address_width = 4,
  parameter logic [address_width-1:0] write_address = 1,
  parameter logic [address_width-1:0] read_address  = 0,
  parameter logic [address_width-1:0] idle_address  = '1,
  parameter int                     read_latency  = 1,
  parameter int                     max_burst     = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  output logic [address_width-1:0]     active_address,
  output logic                         write_enable,
  output logic                         read_enable,
  output logic [width-1:0]             data_in,
  input  logic [width-1:0]             data_out,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic                         cmd_write,
  input  logic [$clog2(max_burst):0]   cmd_length,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic [width-1:0]             wr_data,
  output logic                         rd_valid,
  input  logic                         rd_ready,
  output logic [width-1:0]             rd_data,
  output logic                         busy,
  output logic                         done
);

  localparam int LW = $clog2(max_burst) + 1;

  bus_state_t    state_q;
  bus_dir_t      dir_q;
  logic [LW-1:0] remaining_q;
  logic          lat_expired;
  logic          lat_load;
  logic          lat_tick;
  logic          word_done;

  assign lat_load  = (state_q == RD_STROBE);
  assign lat_tick  = (state_q == RD_WAIT);
  assign word_done = (state_q == WR_STROBE) || ((state_q == RD_HOLD) && rd_ready);

  latency_counter #(.latency(read_latency)) u_latency_counter (
    .clock   (clock),
    .reset   (reset),
    .load    (lat_load),
    .tick    (lat_tick),
    .expired (lat_expired)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      dir_q          <= READ;
      remaining_q    <= '0;
      active_address <= idle_address;
      write_enable   <= 1'b0;
      read_enable    <= 1'b0;
      data_in        <= '0;
      cmd_ready      <= 1'b1;
      wr_ready       <= 1'b0;
      rd_valid       <= 1'b0;
      rd_data        <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            dir_q     <= cmd_write ? WRITE : READ;
            remaining_q <= (cmd_length > LW'(max_burst)) ? LW'(max_burst) : cmd_length;
            if (cmd_length == '0) begin
              state_q <= DONE;
              done    <= 1'b1;
            end else if (cmd_write) begin
              state_q  <= WR_WAIT;
              wr_ready <= 1'b1;
            end else begin
              state_q        <= RD_STROBE;
              read_enable    <= 1'b1;
              active_address <= read_address;
            end
          end
        end
        WR_WAIT: begin
          if (wr_valid) begin
            state_q        <= WR_STROBE;
            wr_ready       <= 1'b0;
            write_enable   <= 1'b1;
            active_address <= write_address;
            data_in        <= wr_data;
          end
        end
        WR_STROBE: begin
          write_enable   <= 1'b0;
          active_address <= idle_address;
        end
        RD_STROBE: begin
          state_q        <= RD_WAIT;
          read_enable    <= 1'b0;
          active_address <= idle_address;
        end
        RD_WAIT: begin
          if (lat_expired) begin
            state_q  <= RD_HOLD;
            rd_data  <= data_out;
            rd_valid <= 1'b1;
          end
        end
        RD_HOLD: begin
          if (rd_ready) rd_valid <= 1'b0;
        end
        DONE: begin
          state_q   <= IDLE;
          done      <= 1'b0;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase

      // Shared end-of-word step for both directions.
      if (word_done) begin
        remaining_q <= remaining_q - LW'(1);
        if (remaining_q == LW'(1)) begin
          state_q <= DONE;
          done    <= 1'b1;
        end else if (dir_q == WRITE) begin
          state_q  <= WR_WAIT;
          wr_ready <= 1'b1;
        end else begin
          state_q        <= RD_STROBE;
          read_enable    <= 1'b1;
          active_address <= read_address;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_bus_initiator.sv
// Directed bench for uart_bus_initiator: bursts, length boundaries, reset
// mid-burst and a random traffic phase checking bus exclusivity.
module tb_uart_bus_initiator;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] active_address;
  logic       write_enable;
  logic       read_enable;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [4:0] cmd_length;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] wr_data;
  logic       rd_valid;
  logic       rd_ready;
  logic [7:0] rd_data;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  uart_bus_initiator dut (
    .clock          (clock),
    .reset          (reset),
    .active_address (active_address),
    .write_enable   (write_enable),
    .read_enable    (read_enable),
    .data_in        (data_in),
    .data_out       (data_out),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_write      (cmd_write),
    .cmd_length     (cmd_length),
    .wr_valid       (wr_valid),
    .wr_ready       (wr_ready),
    .wr_data        (wr_data),
    .rd_valid       (rd_valid),
    .rd_ready       (rd_ready),
    .rd_data        (rd_data),
    .busy           (busy),
    .done           (done)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_we"},   write_enable,   0);
    chk({tag, "_re"},   read_enable,    0);
    chk({tag, "_addr"}, active_address, 4'hF);
    chk({tag, "_din"},  data_in,        0);
    chk({tag, "_rdv"},  rd_valid,       0);
    chk({tag, "_rdd"},  rd_data,        0);
    chk({tag, "_wrr"},  wr_ready,       0);
    chk({tag, "_cmdr"}, cmd_ready,      1);
    chk({tag, "_busy"}, busy,           0);
    chk({tag, "_done"}, done,           0);
  endtask

  initial begin
    int  n;
    bit  seen;

    reset      = 1'b1;
    data_out   = 8'h00;
    cmd_valid  = 1'b0;
    cmd_write  = 1'b0;
    cmd_length = 5'd0;
    wr_valid   = 1'b0;
    wr_data    = 8'h00;
    rd_ready   = 1'b0;
    tick();
    tick();
    chk_reset_values("rst");
    reset = 1'b0;
    tick();

    // Write burst of three back-to-back words.
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_length = 5'd3;
    wr_valid = 1'b1; wr_data = 8'h41;
    tick();
    cmd_valid = 1'b0;
    chk("wr_accept_wrr", wr_ready, 1);
    chk("wr_accept_busy", busy, 1);
    chk("wr_accept_cmdr", cmd_ready, 0);
    chk("wr_accept_we", write_enable, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("wr_strobe_we", write_enable, 1);
      chk("wr_strobe_re", read_enable, 0);
      chk("wr_strobe_addr", active_address, 4'h1);
      chk("wr_strobe_data", data_in, 32'h41 + i);
      wr_data = 8'h42 + 8'(i);
      tick();
      chk("wr_gap_we", write_enable, 0);
      chk("wr_gap_addr", active_address, 4'hF);
      chk("wr_gap_data_hold", data_in, 32'h41 + i);
      chk("wr_gap_done", done, (i == 2) ? 1 : 0);
      if (i < 2) chk("wr_gap_wrr", wr_ready, 1);
    end
    wr_valid = 1'b0;
    tick();
    chk("wr_end_done", done, 0);
    chk("wr_end_cmdr", cmd_ready, 1);
    chk("wr_end_busy", busy, 0);

    // Read burst of two, rd_ready held low for four cycles.
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_length = 5'd2; rd_ready = 1'b0;
    tick();
    cmd_valid = 1'b0;
    chk("rd1_strobe_re", read_enable, 1);
    chk("rd1_strobe_we", write_enable, 0);
    chk("rd1_strobe_addr", active_address, 4'h0);
    data_out = 8'h5A;
    tick();
    chk("rd1_wait_re", read_enable, 0);
    chk("rd1_wait_addr", active_address, 4'hF);
    chk("rd1_wait_rdv", rd_valid, 0);
    tick();
    data_out = 8'h00;
    for (int i = 0; i < 4; i++) begin
      chk("rd1_hold_rdv", rd_valid, 1);
      chk("rd1_hold_data", rd_data, 8'h5A);
      chk("rd1_hold_re", read_enable, 0);
      if (i < 3) tick();
    end
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    chk("rd2_strobe_re", read_enable, 1);
    chk("rd2_strobe_addr", active_address, 4'h0);
    chk("rd2_strobe_rdv", rd_valid, 0);
    data_out = 8'hA5;
    tick();
    chk("rd2_wait_re", read_enable, 0);
    tick();
    data_out = 8'h00;
    chk("rd2_hold_rdv", rd_valid, 1);
    chk("rd2_hold_data", rd_data, 8'hA5);
    chk("rd2_hold_done", done, 0);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    chk("rd_done", done, 1);
    chk("rd_done_rdv", rd_valid, 0);
    chk("rd_done_re", read_enable, 0);
    tick();
    chk("rd_end_cmdr", cmd_ready, 1);
    chk("rd_end_done", done, 0);

    // Zero-length command.
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_length = 5'd0;
    tick();
    cmd_valid = 1'b0;
    chk("len0_done", done, 1);
    chk("len0_we", write_enable, 0);
    chk("len0_wrr", wr_ready, 0);
    chk("len0_cmdr", cmd_ready, 0);
    tick();
    chk("len0_cmdr_back", cmd_ready, 1);
    chk("len0_done_end", done, 0);

    // Length 31 clamps to 16; cmd_valid stays high through the burst.
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_length = 5'd31;
    wr_valid = 1'b1; wr_data = 8'h10;
    n = 0; seen = 0;
    for (int c = 0; c < 100 && !seen; c++) begin
      tick();
      if (write_enable) n++;
      if (done) seen = 1;
    end
    cmd_valid = 1'b0; wr_valid = 1'b0;
    chk("len31_done_seen", seen, 1);
    chk("len31_strobes", n, 16);
    tick();
    chk("len31_idle_cmdr", cmd_ready, 1);
    tick();
    chk("len31_not_restarted", busy, 0);

    // Reset in WR_WAIT of a 5-word burst after two words.
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_length = 5'd5;
    wr_valid = 1'b1; wr_data = 8'h33;
    tick();
    cmd_valid = 1'b0;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (write_enable) n++;
    end
    chk("rstmid_two_words", n, 2);
    chk("rstmid_in_wr_wait", wr_ready, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_reset_values("rstmid");
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (write_enable || read_enable) n++;
    end
    chk("rstmid_no_strobes", n, 0);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_length = 5'd1; wr_data = 8'h77;
    tick();
    cmd_valid = 1'b0;
    chk("rstmid_new_accept", wr_ready, 1);
    tick();
    chk("rstmid_new_we", write_enable, 1);
    chk("rstmid_new_data", data_in, 8'h77);
    tick();
    chk("rstmid_new_done", done, 1);
    wr_valid = 1'b0;
    tick();

    // Random traffic.
    for (int c = 0; c < 1000; c++) begin
      cmd_valid  = 1'($urandom_range(0, 1));
      cmd_write  = 1'($urandom_range(0, 1));
      cmd_length = 5'($urandom_range(0, 20));
      wr_valid   = 1'($urandom_range(0, 1));
      wr_data    = 8'($urandom);
      rd_ready   = 1'($urandom_range(0, 1));
      data_out   = 8'($urandom);
      tick();
      chk("rand_exclusive", write_enable && read_enable, 0);
      chk("rand_busy_vs_ready", busy, !cmd_ready);
      if (write_enable)
        chk("rand_wr_addr", active_address, 4'h1);
      else if (read_enable)
        chk("rand_rd_addr", active_address, 4'h0);
      else
        chk("rand_idle_addr", active_address, 4'hF);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_bus_initiator.md
UART_BUS_INITIATOR -- requirements
Module: uart_bus_initiator

Interface
REQ-001 SHALL have parameters: width, 8, bus data word width; address_width, 4, bus address width; write_address, 1, peripheral transmit-queue address; read_address, 0, peripheral receive-queue address; idle_address, all ones, address driven when no transfer; read_latency, 1, cycles from read strobe to valid data_out; max_burst, 16, max words per command.
REQ-002 SHALL have one clock; reset is synchronous and active-high; ports named clock and reset.
REQ-003 SHALL have ports (name direction width meaning): clock in 1 clock; reset in 1 sync active-high reset; active_address out address_width bus address; write_enable out 1 bus write strobe; read_enable out 1 bus read strobe; data_in out width bus write data to peripheral; data_out in width bus read data from peripheral.
REQ-004 SHALL have command ports: cmd_valid in 1; cmd_ready out 1; cmd_write in 1 (1=write burst, 0=read burst); cmd_length in $clog2(max_burst)+1 word count.
REQ-005 SHALL have stream ports: wr_valid in 1; wr_ready out 1; wr_data in width; rd_valid out 1; rd_ready in 1; rd_data out width; busy out 1; done out 1 one-cycle completion pulse.

Function
REQ-006 SHALL implement states IDLE, WR_WAIT, WR_STROBE, RD_STROBE, RD_WAIT, RD_HOLD, DONE.
REQ-007 SHALL assert cmd_ready only in IDLE; command accepted on cmd_valid&&cmd_ready, latching cmd_write and length.
REQ-008 SHALL clamp accepted length above max_burst to max_burst; length 0 SHALL go IDLE->DONE with no bus strobe.
REQ-009 Write: WR_WAIT SHALL assert wr_ready; on wr_valid&&wr_ready capture wr_data, go WR_STROBE.
REQ-010 WR_STROBE SHALL drive write_enable=1, active_address=write_address, data_in=captured word for exactly one cycle, then decrement remaining count; WR_WAIT if nonzero else DONE.
REQ-011 Read: RD_STROBE SHALL drive read_enable=1, active_address=read_address for exactly one cycle, then RD_WAIT.
REQ-012 RD_WAIT SHALL count read_latency cycles after the strobe cycle (read_latency=1: capture on first RD_WAIT cycle), capture data_out into rd_data, assert rd_valid, go RD_HOLD.
REQ-013 RD_HOLD SHALL hold rd_valid and rd_data stable until rd_ready; on handshake decrement count; RD_STROBE if nonzero else DONE; no new read strobe while rd_valid is high.
REQ-014 DONE SHALL pulse done=1 for one cycle, return to IDLE.
REQ-015 write_enable and read_enable SHALL never be high in the same cycle; outside strobe cycles both 0, active_address=idle_address, data_in holds last value.
REQ-016 busy SHALL be 1 in every state except IDLE.
REQ-017 Peak throughput: one write per 2 cycles given continuous wr_valid; one read per read_latency+2 cycles given continuous rd_ready.
REQ-018 cmd_valid during a burst SHALL be ignored (not accepted, not lost by module—held by source until cmd_ready).

Reset
REQ-019 On reset SHALL go IDLE next cycle regardless of state, abandoning any burst.
REQ-020 Reset values: write_enable=0, read_enable=0, active_address=idle_address, data_in=0, rd_valid=0, rd_data=0, wr_ready=0, cmd_ready=1 (in IDLE), busy=0, done=0, counters 0.

Structure
REQ-021 State enum and a bus-direction enum (READ/WRITE) SHALL live in shared package uart_bus_pkg, reused by the peripheral's addressable logic.
REQ-022 Latency counter SHALL be sub-module latency_counter (load, tick, expired); all else in one always_ff FSM.

Verification
REQ-023 Write burst length 3, wr_data 0x41,0x42,0x43 back-to-back -> three single-cycle write_enable pulses at address 1, data_in 0x41,0x42,0x43, 2 cycles apart, done one cycle after last strobe.
REQ-024 Read burst length 2, data_out 0x5A then 0xA5 one cycle after each strobe, rd_ready held low 4 cycles -> rd_valid holds 0x5A stable 4 cycles, second read_enable only after handshake, done after second handshake.
REQ-025 cmd_length 0 -> done pulse, no strobes, cmd_ready high again 2 cycles after accept; cmd_length 31 -> exactly 16 strobes.
REQ-026 Reset asserted during WR_WAIT of a 5-word burst after 2 words -> next cycle all outputs at reset values, no further strobes, new command accepted.
REQ-027 Random traffic 1000 cycles -> write_enable&&read_enable never both 1; active_address==idle_address whenever no strobe.
